ysyx_22050133_mem_arbiter: RTL



---
 rtl/ysyx_22050133_mem_arbiter_pkg.sv | 26 ++
 rtl/ysyx_22050133_mem_arbiter_rr_arb2.sv | 19 +
 rtl/ysyx_22050133_mem_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_mem_arbiter_pkg.sv
// Shared types and bus codes for the cache-to-bridge memory arbiter.
// Also provides the beat-count helper used by the burst tracker.
package ysyx_22050133_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWdata,
        StRdata
    } arb_state_e;

    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_1 = 3'b000;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_2 = 3'b001;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_4 = 3'b010;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_8 = 3'b011;

    localparam logic [1:0] AXI_BURST_TYPE_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_TYPE_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_TYPE_WRAP  = 2'b10;

    // beat_cnt holds beats remaining minus one, so zero marks the final beat.
    function automatic logic last_beat(input logic [7:0] cnt);
        return cnt == 8'd0;
    endfunction

endpackage

// File: rtl/ysyx_22050133_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester that was
// not served last wins.
module ysyx_22050133_rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic grant_o
);

    always_comb begin
        grant_o = 1'b0;
        if (req0_i && req1_i) begin
            grant_o = ~last_i;
        end else if (req1_i) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22050133_mem_arbiter.sv
// Arbiter sharing the AXI-bridge rw port between icache (m0) and dcache (m1).
// One grant per burst, held until the last data beat; data paths are pure muxes.
module ysyx_22050133_mem_arbiter
    import ysyx_22050133_mem_arbiter_pkg::*;
#(
    parameter int unsigned RW_DATA_WIDTH = 64,
    parameter int unsigned RW_ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     m0_rw_addr_valid_i,
    output logic                     m0_rw_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] m0_rw_addr_i,
    input  logic                     m0_rw_we_i,
    input  logic [7:0]               m0_rw_len_i,
    input  logic [2:0]               m0_rw_size_i,
    input  logic [1:0]               m0_rw_burst_i,
    input  logic                     m0_rw_if_i,
    input  logic                     m0_w_data_valid_i,
    output logic                     m0_w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] m0_w_data_i,
    output logic                     m0_r_data_valid_o,
    input  logic                     m0_r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] m0_r_data_o,

    input  logic                     m1_rw_addr_valid_i,
    output logic                     m1_rw_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] m1_rw_addr_i,
    input  logic                     m1_rw_we_i,
    input  logic [7:0]               m1_rw_len_i,
    input  logic [2:0]               m1_rw_size_i,
    input  logic [1:0]               m1_rw_burst_i,
    input  logic                     m1_rw_if_i,
    input  logic                     m1_w_data_valid_i,
    output logic                     m1_w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] m1_w_data_i,
    output logic                     m1_r_data_valid_o,
    input  logic                     m1_r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] m1_r_data_o,

    output logic                     axi_rw_addr_valid_o,
    input  logic                     axi_rw_addr_ready_i,
    output logic [RW_ADDR_WIDTH-1:0] axi_rw_addr_o,
    output logic                     axi_rw_we_o,
    output logic [7:0]               axi_rw_len_o,
    output logic [2:0]               axi_rw_size_o,
    output logic [1:0]               axi_rw_burst_o,
    output logic                     axi_rw_if_o,
    output logic                     axi_w_data_valid_o,
    input  logic                     axi_w_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] axi_w_data_o,
    input  logic                     axi_r_data_valid_i,
    output logic                     axi_r_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] axi_r_data_i
);

    arb_state_e state_q;
    logic       grant_q;
    logic       last_q;
    logic       we_q;
    logic [7:0] beat_cnt_q;
    logic       pick;

    logic                     sel_addr_valid;
    logic [RW_ADDR_WIDTH-1:0] sel_addr;
    logic                     sel_we;
    logic [7:0]               sel_len;
    logic [2:0]               sel_size;
    logic [1:0]               sel_burst;
    logic                     sel_if;
    logic                     sel_w_valid;
    logic [RW_DATA_WIDTH-1:0] sel_w_data;
    logic                     sel_r_ready;
    logic                     beat_hs;

    logic                     addr_ready;
    logic                     w_ready;
    logic                     r_valid;
    logic [RW_DATA_WIDTH-1:0] r_data;

    ysyx_22050133_rr_arb2 u_rr_arb2 (
        .req0_i  (m0_rw_addr_valid_i),
        .req1_i  (m1_rw_addr_valid_i),
        .last_i  (last_q),
        .grant_o (pick)
    );

    assign sel_addr_valid = grant_q ? m1_rw_addr_valid_i : m0_rw_addr_valid_i;
    assign sel_addr       = grant_q ? m1_rw_addr_i       : m0_rw_addr_i;
    assign sel_we         = grant_q ? m1_rw_we_i         : m0_rw_we_i;
    assign sel_len        = grant_q ? m1_rw_len_i        : m0_rw_len_i;
    assign sel_size       = grant_q ? m1_rw_size_i       : m0_rw_size_i;
    assign sel_burst      = grant_q ? m1_rw_burst_i      : m0_rw_burst_i;
    assign sel_if         = grant_q ? m1_rw_if_i         : m0_rw_if_i;
    assign sel_w_valid    = grant_q ? m1_w_data_valid_i  : m0_w_data_valid_i;
    assign sel_w_data     = grant_q ? m1_w_data_i        : m0_w_data_i;
    assign sel_r_ready    = grant_q ? m1_r_data_ready_i  : m0_r_data_ready_i;

    // we_q picks which channel's handshake advances the beat counter.
    assign beat_hs = we_q ? (sel_w_valid && axi_w_data_ready_i)
                          : (axi_r_data_valid_i && sel_r_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= 1'b0;
            last_q     <= 1'b0;
            we_q       <= 1'b0;
            beat_cnt_q <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m0_rw_addr_valid_i || m1_rw_addr_valid_i) begin
                        grant_q <= pick;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (!sel_addr_valid) begin
                        state_q <= StIdle;
                    end else if (axi_rw_addr_ready_i) begin
                        we_q       <= sel_we;
                        beat_cnt_q <= sel_len;
                        last_q     <= grant_q;
                        state_q    <= sel_we ? StWdata : StRdata;
                    end
                end
                StWdata, StRdata: begin
                    if (beat_hs) begin
                        if (last_beat(beat_cnt_q)) begin
                            state_q <= StIdle;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        axi_rw_addr_valid_o = 1'b0;
        axi_rw_addr_o       = '0;
        axi_rw_we_o         = 1'b0;
        axi_rw_len_o        = 8'd0;
        axi_rw_size_o       = 3'd0;
        axi_rw_burst_o      = 2'd0;
        axi_rw_if_o         = 1'b0;
        axi_w_data_valid_o  = 1'b0;
        axi_w_data_o        = '0;
        axi_r_data_ready_o  = 1'b0;
        addr_ready          = 1'b0;
        w_ready             = 1'b0;
        r_valid             = 1'b0;
        r_data              = '0;
        unique case (state_q)
            StAddr: begin
                axi_rw_addr_valid_o = sel_addr_valid;
                axi_rw_addr_o       = sel_addr;
                axi_rw_we_o         = sel_we;
                axi_rw_len_o        = sel_len;
                axi_rw_size_o       = sel_size;
                axi_rw_burst_o      = sel_burst;
                axi_rw_if_o         = sel_if;
                addr_ready          = axi_rw_addr_ready_i;
            end
            StWdata: begin
                axi_w_data_valid_o = sel_w_valid;
                axi_w_data_o       = sel_w_data;
                w_ready            = axi_w_data_ready_i;
            end
            StRdata: begin
                r_valid            = axi_r_data_valid_i;
                r_data             = axi_r_data_i;
                axi_r_data_ready_o = sel_r_ready;
            end
            default: ;
        endcase
    end

    assign m0_rw_addr_ready_o = addr_ready & ~grant_q;
    assign m0_w_data_ready_o  = w_ready    & ~grant_q;
    assign m0_r_data_valid_o  = r_valid    & ~grant_q;
    assign m0_r_data_o        = grant_q ? '0 : r_data;
    assign m1_rw_addr_ready_o = addr_ready & grant_q;
    assign m1_w_data_ready_o  = w_ready    & grant_q;
    assign m1_r_data_valid_o  = r_valid    & grant_q;
    assign m1_r_data_o        = grant_q ? r_data : '0;

endmodule
